// File: rtl/mux_scan_pkg.sv
// Shared constants, types and helpers for the mux_scan channel scanner.
// Mode encodings are also used by any block that drives mux_scan.mode.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Per-edge decision taken by the auto-scan logic.
  typedef enum logic [1:0] {
    SCAN_IDLE    = 2'd0,
    SCAN_DWELL   = 2'd1,
    SCAN_ADVANCE = 2'd2,
    SCAN_SKIP    = 2'd3
  } scan_action_e;

  // Channel-index width: never narrower than one bit.
  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Round-robin search for the next enabled channel strictly above cur,
// wrapping to 0; cur itself is only returned when it is the sole candidate.
module mux_scan_next
  import mux_scan_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [SEL_W-1:0]    cur,
  input  logic [CHANNELS-1:0] enable_mask,
  output logic [SEL_W-1:0]    next_chan,
  output logic                any_enabled
);

  logic [2*CHANNELS-1:0] mask_dbl;
  logic [CHANNELS-1:0]   mask_rot;
  logic                  found;
  int                    offset;
  int                    target;

  // Bit j of mask_rot is the enable of channel (cur + 1 + j) mod CHANNELS.
  assign mask_dbl    = {enable_mask, enable_mask};
  assign mask_rot    = mask_dbl[int'(cur) + 1 +: CHANNELS];
  assign any_enabled = |enable_mask;

  always_comb begin
    found  = 1'b0;
    offset = 0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (!found && mask_rot[j]) begin
        found  = 1'b1;
        offset = j;
      end
    end

    target = int'(cur) + 1 + offset;
    if (target >= CHANNELS) begin
      target = target - CHANNELS;
    end

    next_chan = cur;
    if (found) begin
      next_chan = SEL_W'(target);
    end
  end

endmodule

// File: rtl/mux_scan.sv
// Registered N-to-1 channel multiplexer with manual select and an auto-scan
// mode that dwells DWELL cycles per enabled channel.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       enable_mask,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      out_valid,
  output logic                      chan_change
);

  localparam int                DCNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

  logic [SEL_W-1:0]  cur;
  logic [SEL_W-1:0]  cur_n;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dcnt_n;
  logic [SEL_W-1:0]  next_chan;
  logic              any_enabled;
  logic              sel_ok;
  logic              valid_n;
  scan_action_e      action;

  mux_scan_next #(
    .CHANNELS (CHANNELS)
  ) u_next (
    .cur         (cur),
    .enable_mask (enable_mask),
    .next_chan   (next_chan),
    .any_enabled (any_enabled)
  );

  assign sel_ok = (int'(sel) < CHANNELS);

  // out_valid qualifies data_out/chan_out in the same cycle: it is high only
  // when the presented channel is enabled and was reached by a legal select.
  assign valid_n = enable_mask[cur] & ~((mode == MODE_MANUAL) & ~sel_ok);

  // Manual mode parks dcnt at 0, so entering auto always starts a fresh dwell.
  always_comb begin
    cur_n  = cur;
    dcnt_n = dcnt;
    action = SCAN_IDLE;

    if (mode == MODE_AUTO) begin
      if (!any_enabled) begin
        action = SCAN_IDLE;
      end else if (!enable_mask[cur]) begin
        action = SCAN_SKIP;
      end else if (hold) begin
        action = SCAN_IDLE;
      end else if (dcnt == DCNT_LAST) begin
        action = SCAN_ADVANCE;
      end else begin
        action = SCAN_DWELL;
      end

      case (action)
        SCAN_DWELL: begin
          dcnt_n = dcnt + 1'b1;
        end
        SCAN_ADVANCE, SCAN_SKIP: begin
          cur_n  = next_chan;
          dcnt_n = '0;
        end
        default: begin
          cur_n  = cur;
          dcnt_n = dcnt;
        end
      endcase
    end else begin
      dcnt_n = '0;
      if (sel_ok) begin
        cur_n = sel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur         <= '0;
      dcnt        <= '0;
      data_out    <= '0;
      chan_out    <= '0;
      out_valid   <= 1'b0;
      chan_change <= 1'b0;
    end else begin
      cur         <= cur_n;
      dcnt        <= dcnt_n;
      data_out    <= data_in[int'(cur)*WIDTH +: WIDTH];
      chan_out    <= cur;
      out_valid   <= valid_n;
      chan_change <= (cur != chan_out);
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: directed scenarios followed by a random
// phase, all compared against a list-based reference model of the scanner.
module tb_mux_scan;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 3;
  localparam int SEL_W    = 2;
  localparam int EXP_W    = WIDTH + SEL_W + 2;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       enable_mask;
  logic                      hold;
  logic [WIDTH-1:0]          data_out;
  logic [SEL_W-1:0]          chan_out;
  logic                      out_valid;
  logic                      chan_change;

  int               tests = 0;
  int               fails = 0;
  string            phase = "init";
  logic [EXP_W-1:0] exp_q[$];
  logic [WIDTH-1:0] chan_data[CHANNELS];

  // Reference model: current channel, dwell position and last presented channel.
  int m_cur  = 0;
  int m_dcnt = 0;
  int m_chan = 0;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  mux_scan #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .mode        (mode),
    .sel         (sel),
    .enable_mask (enable_mask),
    .hold        (hold),
    .data_out    (data_out),
    .chan_out    (chan_out),
    .out_valid   (out_valid),
    .chan_change (chan_change)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, expv);
    end
  endtask

  function automatic int next_enabled(input int cur, input logic [CHANNELS-1:0] mask);
    int en[$];
    for (int k = 0; k < CHANNELS; k++) if (mask[k]) en.push_back(k);
    foreach (en[i]) if (en[i] > cur) return en[i];
    return en[0];
  endfunction

  // ---------------- driver ----------------
  task automatic drive_data();
    for (int k = 0; k < CHANNELS; k++) data_in[k*WIDTH +: WIDTH] = chan_data[k];
  endtask

  // One clock edge: predict outputs from model state, advance the model by the
  // scanner rules, then compare the DUT one time-step after the edge.
  task automatic tick();
    logic [EXP_W-1:0] e;
    if (reset) begin
      e      = '0;
      m_cur  = 0;
      m_dcnt = 0;
      m_chan = 0;
    end else begin
      e      = {chan_data[m_cur], SEL_W'(m_cur), enable_mask[m_cur], 1'(m_cur != m_chan)};
      m_chan = m_cur;
      if (mode == 1'b0) begin
        m_cur  = int'(sel);
        m_dcnt = 0;
      end else if (enable_mask == '0) begin
        // nothing eligible: freeze
      end else if (!enable_mask[m_cur]) begin
        m_cur  = next_enabled(m_cur, enable_mask);
        m_dcnt = 0;
      end else if (hold) begin
        // frozen by hold
      end else if (m_dcnt == DWELL - 1) begin
        m_cur  = next_enabled(m_cur, enable_mask);
        m_dcnt = 0;
      end else begin
        m_dcnt++;
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("data",   32'(data_out),    32'(e[EXP_W-1 -: WIDTH]));
    check("chan",   32'(chan_out),    32'(e[3:2]));
    check("valid",  32'(out_valid),   32'(e[1]));
    check("change", 32'(chan_change), 32'(e[0]));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq32[13];
    int seq33[7];
    int seq36[4];
    int cnt2;
    logic [SEL_W-1:0] prev_chan;

    seq32 = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    seq33 = '{1, 1, 1, 3, 3, 3, 1};
    seq36 = '{0, 0, 0, 1};

    chan_data   = '{8'h11, 8'h22, 8'h33, 8'h44};
    drive_data();
    reset       = 1'b1;
    mode        = 1'b0;
    sel         = '0;
    enable_mask = 4'b1111;
    hold        = 1'b0;
    @(negedge clock);

    phase = "reset";
    do_reset();
    check("rst_data",  32'(data_out), 32'h0);
    check("rst_chan",  32'(chan_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);

    phase = "manual";
    sel = 2'd2;
    tick();
    tick();
    check("m_data",   32'(data_out),    32'h33);
    check("m_chan",   32'(chan_out),    32'd2);
    check("m_valid",  32'(out_valid),   32'd1);
    check("m_change", 32'(chan_change), 32'd1);
    tick();
    check("m_change_off", 32'(chan_change), 32'd0);

    phase = "auto_full";
    reset = 1'b1;
    mode  = 1'b1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick();
      check("seq_chan", 32'(chan_out), 32'(seq32[i]));
      check("seq_change", 32'(chan_change), 32'((i > 0) && (seq32[i] != seq32[i-1])));
    end

    phase = "auto_1010";
    enable_mask = 4'b1010;
    do_reset();
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      check("seq_chan", 32'(chan_out), 32'(seq33[i]));
    end
    repeat (3) tick();
    check("on3", 32'(chan_out), 32'd3);
    enable_mask = 4'b0010;
    tick();
    check("drop3_valid", 32'(out_valid), 32'd0);
    tick();
    check("drop3_chan",   32'(chan_out),    32'd1);
    check("drop3_change", 32'(chan_change), 32'd1);

    phase = "hold";
    enable_mask = 4'b1111;
    do_reset();
    cnt2 = 0;
    repeat (7) begin tick(); if (chan_out == 2'd2) cnt2++; end
    hold = 1'b1;
    repeat (5) begin tick(); if (chan_out == 2'd2) cnt2++; end
    hold = 1'b0;
    repeat (4) begin tick(); if (chan_out == 2'd2) cnt2++; end
    check("ch2_cycles", 32'(cnt2), 32'd8);
    check("after_hold", 32'(chan_out), 32'd3);

    phase = "mask_zero";
    enable_mask = 4'b0000;
    repeat (4) begin
      tick();
      check("z_valid",  32'(out_valid),   32'd0);
      check("z_chan",   32'(chan_out),    32'd3);
      check("z_change", 32'(chan_change), 32'd0);
    end

    phase = "mid_reset";
    enable_mask = 4'b1111;
    do_reset();
    repeat (7) tick();
    check("pre_chan", 32'(chan_out), 32'd2);
    do_reset();
    check("r_data",   32'(data_out),    32'h0);
    check("r_chan",   32'(chan_out),    32'h0);
    check("r_valid",  32'(out_valid),   32'h0);
    check("r_change", 32'(chan_change), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("restart", 32'(chan_out), 32'(seq36[i]));
    end

    phase = "random";
    prev_chan = chan_out;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      sel  = SEL_W'($urandom_range(0, CHANNELS - 1));
      hold = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) enable_mask = CHANNELS'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < CHANNELS; k++) chan_data[k] = WIDTH'($urandom);
        drive_data();
      end
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each data channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (legal range 2..256).
REQ-003 SHALL have parameter DWELL, default 4, clock cycles spent on each channel in auto mode (legal range ≥1).
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port data_in, input, CHANNELS*WIDTH, packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port mode, input, 1, with 0 = manual select and 1 = auto-scan.
REQ-008 SHALL have port sel, input, SEL_W = max(1, clog2(CHANNELS)), the channel index used in manual mode.
REQ-009 SHALL have port enable_mask, input, CHANNELS, where bit k = 1 makes channel k eligible in auto mode and valid in either mode.
REQ-010 SHALL have port hold, input, 1, which freezes auto-scan advancement.
REQ-011 SHALL have port data_out, output, WIDTH, the registered selected channel data.
REQ-012 SHALL have port chan_out, output, SEL_W, the index of the channel currently presented on data_out.
REQ-013 SHALL have port out_valid, output, 1, high when data_out comes from an enabled, in-range channel.
REQ-014 SHALL have port chan_change, output, 1, a one-cycle pulse whenever chan_out differs from its previous value.

Function
REQ-015 SHALL hold internal state: a current-channel register cur of width SEL_W and a dwell counter dcnt counting 0..DWELL-1.
REQ-016 SHALL, on each edge, update data_out <= data_in[cur], chan_out <= cur and out_valid <= enable_mask[cur], giving one cycle of latency from cur to the outputs.
REQ-017 SHALL, in manual mode, load cur <= sel on each edge; if sel ≥ CHANNELS, cur SHALL hold its value and out_valid SHALL be 0.
REQ-018 SHALL, in manual mode, keep dcnt at 0.
REQ-019 SHALL, in auto mode with hold = 0, increment dcnt each edge; when dcnt = DWELL-1, dcnt SHALL return to 0 and cur SHALL advance to the next enabled channel above cur, wrapping from CHANNELS-1 to 0.
REQ-020 SHALL, if exactly one channel is enabled in auto mode, keep cur on that channel with no chan_change pulses.
REQ-021 SHALL, in auto mode with hold = 1, freeze both dcnt and cur.
REQ-022 SHALL, in auto mode, advance cur to the next enabled channel at the next edge if the current channel is disabled and any channel is enabled, regardless of dwell or hold, with dcnt <= 0.
REQ-023 SHALL, in auto mode with enable_mask all zero, hold cur and dcnt, with out_valid = 0.
REQ-024 SHALL, when mode changes from 0 to 1, clear dcnt and begin the scan from the present cur.
REQ-025 SHALL, when mode changes from 1 to 0, load sel at the same edge.
REQ-026 SHALL register chan_change as (cur != chan_out) on each edge.

Reset
REQ-027 SHALL, when reset = 1 at an edge, set cur, dcnt, data_out, chan_out, out_valid and chan_change to 0, taking priority over all other inputs, including mid-dwell.
REQ-028 SHALL, after reset deasserts, resume operation from channel 0 with a fresh dwell count.

Structure
REQ-029 SHALL place the MODE_MANUAL = 0 and MODE_AUTO = 1 constants in shared package mux_scan_pkg.
REQ-030 SHALL implement the next-enabled-channel search (round-robin priority find above cur with wrap, plus an any_enabled flag) as combinational sub-module mux_scan_next.

Verification
All scenarios use WIDTH = 8, CHANNELS = 4, DWELL = 3, and data_in channels 0..3 = 0x11, 0x22, 0x33, 0x44.
REQ-031 SHALL verify that manual mode with sel = 2 and mask 4'b1111 gives, one edge later, data_out = 0x33, chan_out = 2, out_valid = 1 and chan_change = 1 for one cycle.
REQ-032 SHALL verify that auto mode with mask 4'b1111 from reset gives chan_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0, with chan_change pulsing at each transition.
REQ-033 SHALL verify that auto mode with mask 4'b1010 visits only channels 1 and 3 (1,1,1,3,3,3,1), and that clearing bit 3 while on channel 3 moves to channel 1 at the next edge.
REQ-034 SHALL verify that in auto mode, hold = 1 asserted for 5 cycles at dcnt = 1 on channel 2 keeps chan_out = 2 for exactly 8 cycles in total.
REQ-035 SHALL verify that mask = 4'b0000 in auto mode gives out_valid = 0 after one edge, with chan_out held and no chan_change pulse.
REQ-036 SHALL verify that reset asserted while on channel 2 gives all outputs 0 at the next edge, after which the scan restarts 0,0,0,1.
